chain_score_max: RTL and testbench

Chaining DP reduction stage that consumes the per-pair gap scores produced by the anchor-pair scoring pipeline. For one anchor i it accepts a stream of (predecessor score f[j], pair score, predecessor index j) beats and reduces them to f[i] = max(w_i, max_j(f[j] + score(i,j))) plus the backtrack index of the winning predecessor. It sits directly downstream of the scoring pipeline and upstream of the chain-score/backtrack store.

---
 rtl/chain_score_max.sv | 158 +++++++++++++++
 tb/tb_chain_score_max.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/chain_score_max.sv
// chain_score_max: reduces a stream of (f[j], score(i,j), j) beats for one
// anchor i to f[i] = max(w_i, max_j(f[j] + score(i,j))) and the index of the
// winning predecessor. Earlier candidates (and the seed w_i) win ties.
module chain_score_max #(
    parameter int unsigned IDX_W = 16,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [IDX_W-1:0] anchor_idx,
    input  logic [31:0]      w_i,
    input  logic [CNT_W-1:0] num_pred,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_score,
    input  logic [31:0]      in_fj,
    input  logic [IDX_W-1:0] in_pidx,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_f,
    output logic [IDX_W-1:0] out_p,
    output logic [IDX_W-1:0] out_idx,
    output logic             busy
);

    localparam int unsigned SCORE_W = 32;
    localparam logic [SCORE_W-1:0] SAT_MAX = 32'h7FFF_FFFF;
    localparam logic [SCORE_W-1:0] SAT_MIN = 32'h8000_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [SCORE_W-1:0] best_f_q, best_f_d;
    logic [IDX_W-1:0]   best_p_q, best_p_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q, busy_d;
    logic [SCORE_W-1:0] out_f_q, out_f_d;
    logic [IDX_W-1:0]   out_p_q, out_p_d;
    logic [IDX_W-1:0]   out_idx_q, out_idx_d;

    logic signed [SCORE_W:0] sum_c;
    logic [SCORE_W-1:0]      cand_c;
    logic                    cand_gt_c;
    logic                    accept_c;

    // Candidate f[j] + score, widened by one bit then clamped to 32-bit signed range.
    always_comb begin
        sum_c = $signed({in_fj[SCORE_W-1], in_fj}) + $signed({in_score[SCORE_W-1], in_score});
        if (sum_c[SCORE_W] != sum_c[SCORE_W-1]) begin
            cand_c = sum_c[SCORE_W] ? SAT_MIN : SAT_MAX;
        end else begin
            cand_c = sum_c[SCORE_W-1:0];
        end
        cand_gt_c = $signed(cand_c) > $signed(best_f_q);
        accept_c  = in_valid && in_ready_q;
    end

    // Next-state and datapath update; registered outputs follow the next state.
    always_comb begin
        state_d     = state_q;
        best_f_d    = best_f_q;
        best_p_d    = best_p_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        out_f_d     = out_f_q;
        out_p_d     = out_p_q;
        out_idx_d   = out_idx_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    // w_i is unsigned; values above the signed max clamp to it.
                    best_f_d = w_i[SCORE_W-1] ? SAT_MAX : {1'b0, w_i[SCORE_W-2:0]};
                    best_p_d = '1;
                    idx_d    = anchor_idx;
                    cnt_d    = num_pred;
                    state_d  = (num_pred != '0) ? ST_ACCUM : ST_DONE;
                end
            end
            ST_ACCUM: begin
                if (accept_c) begin
                    if (cand_gt_c) begin
                        best_f_d = cand_c;
                        best_p_d = in_pidx;
                    end
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        in_ready_d  = (state_d == ST_ACCUM);
        out_valid_d = (state_d == ST_DONE);
        busy_d      = (state_d != ST_IDLE);

        // Result registers load once on entry to DONE and hold through backpressure.
        if ((state_d == ST_DONE) && (state_q != ST_DONE)) begin
            out_f_d   = best_f_d;
            out_p_d   = best_p_d;
            out_idx_d = idx_d;
        end
    end

    // State and datapath registers; reset discards any in-progress anchor.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            best_f_q    <= '0;
            best_p_q    <= '0;
            idx_q       <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            out_f_q     <= '0;
            out_p_q     <= '0;
            out_idx_q   <= '0;
        end else begin
            state_q     <= state_d;
            best_f_q    <= best_f_d;
            best_p_q    <= best_p_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            out_f_q     <= out_f_d;
            out_p_q     <= out_p_d;
            out_idx_q   <= out_idx_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign out_f     = out_f_q;
    assign out_p     = out_p_q;
    assign out_idx   = out_idx_q;

endmodule

// File: tb/tb_chain_score_max.sv
// Directed bench for chain_score_max: inputs change and outputs are sampled on
// the falling edge; the DUT acts on the rising edge.
module tb_chain_score_max;

    localparam int unsigned IDX_W = 16;
    localparam int unsigned CNT_W = 8;
    localparam logic [IDX_W-1:0] NO_PRED = 16'hFFFF;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [IDX_W-1:0] anchor_idx;
    logic [31:0]      w_i;
    logic [CNT_W-1:0] num_pred;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_score;
    logic [31:0]      in_fj;
    logic [IDX_W-1:0] in_pidx;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_f;
    logic [IDX_W-1:0] out_p;
    logic [IDX_W-1:0] out_idx;
    logic             busy;

    int checks = 0;
    int errors = 0;

    logic [31:0]      bfj [8];
    logic [31:0]      bsc [8];
    logic [IDX_W-1:0] bpi [8];

    chain_score_max #(.IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .start(start), .anchor_idx(anchor_idx),
        .w_i(w_i), .num_pred(num_pred), .in_valid(in_valid), .in_ready(in_ready),
        .in_score(in_score), .in_fj(in_fj), .in_pidx(in_pidx),
        .out_valid(out_valid), .out_ready(out_ready), .out_f(out_f),
        .out_p(out_p), .out_idx(out_idx), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic set_beat(input int k, input logic [31:0] fj, input logic [31:0] sc,
                            input logic [IDX_W-1:0] pi);
        bfj[k] = fj;
        bsc[k] = sc;
        bpi[k] = pi;
    endtask

    // One complete anchor: start, feed beats, check result, hold, handshake.
    task automatic run_anchor(input string name, input logic [31:0] w,
                              input logic [IDX_W-1:0] aidx, input int n,
                              input bit gaps, input int hold, input bit pulse_start,
                              input logic [31:0] exp_f, input logic [IDX_W-1:0] exp_p,
                              input int exp_lat);
        int cyc;
        int sent;
        bit seen;
        @(negedge clk);
        start = 1'b1; w_i = w; anchor_idx = aidx; num_pred = CNT_W'(n); out_ready = 1'b0;
        @(negedge clk);
        start = 1'b0; cyc = 1; sent = 0; seen = 1'b0;
        checks++;
        if (busy !== 1'b1 || in_ready !== (n != 0)) begin
            errors++;
            $display("FAIL %s after-start: busy=%b in_ready=%b, want busy=1 in_ready=%b",
                     name, busy, in_ready, (n != 0));
        end
        while (!seen && cyc < 200) begin
            if (out_valid === 1'b1) begin
                seen = 1'b1;
            end else begin
                in_valid = 1'b0;
                if (in_ready === 1'b1 && sent < n && !(gaps && $urandom_range(0, 2) == 0)) begin
                    in_valid = 1'b1; in_fj = bfj[sent]; in_score = bsc[sent]; in_pidx = bpi[sent];
                    sent++;
                end
                if (pulse_start) begin
                    start = ($urandom_range(0, 1) == 1);
                    w_i = 32'h7FFF_0000; anchor_idx = 16'hDEAD; num_pred = 8'd1;
                end
                @(negedge clk);
                cyc++;
            end
        end
        in_valid = 1'b0;
        start = 1'b0;
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s timeout: out_valid never rose within %0d cycles", name, cyc);
        end
        if (exp_lat >= 0) begin
            checks++;
            if (cyc != exp_lat) begin
                errors++;
                $display("FAIL %s latency: got %0d cycles, want %0d", name, cyc, exp_lat);
            end
        end
        checks++;
        if (out_f !== exp_f || out_p !== exp_p || out_idx !== aidx) begin
            errors++;
            $display("FAIL %s result: f=%h p=%h idx=%h, want f=%h p=%h idx=%h",
                     name, out_f, out_p, out_idx, exp_f, exp_p, aidx);
        end
        for (int h = 0; h < hold; h++) begin
            start = pulse_start;
            w_i = 32'h0000_0001; anchor_idx = 16'hBEEF; num_pred = 8'd0;
            @(negedge clk);
            start = 1'b0;
            checks++;
            if (out_valid !== 1'b1 || out_f !== exp_f || out_p !== exp_p || out_idx !== aidx) begin
                errors++;
                $display("FAIL %s hold%0d: v=%b f=%h p=%h idx=%h, want v=1 f=%h p=%h idx=%h",
                         name, h, out_valid, out_f, out_p, out_idx, exp_f, exp_p, aidx);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s handshake: v=%b busy=%b in_ready=%b, want 0 0 0",
                     name, out_valid, busy, in_ready);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s single-result: v=%b busy=%b, want 0 0", name, out_valid, busy);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        w_i = '0; anchor_idx = '0; num_pred = '0; in_score = '0; in_fj = '0; in_pidx = '0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 ||
            out_f !== 32'h0 || out_p !== 16'h0 || out_idx !== 16'h0) begin
            errors++;
            $display("FAIL reset-values: rdy=%b v=%b busy=%b f=%h p=%h idx=%h, want all 0",
                     in_ready, out_valid, busy, out_f, out_p, out_idx);
        end
        reset = 1'b0;
    endtask

    task automatic test_basic;
        set_beat(0, 32'd20, 32'd5, 16'd7);
        set_beat(1, 32'd30, -32'sd2, 16'd9);
        set_beat(2, 32'd10, 32'd40, 16'd3);
        run_anchor("basic", 32'd15, 16'h0123, 3, 1'b0, 0, 1'b0, 32'd50, 16'd3, 4);
    endtask

    task automatic test_no_winner;
        set_beat(0, 32'd10, 32'd5, 16'd1);
        set_beat(1, 32'd50, -32'sd60, 16'd2);
        run_anchor("no-winner", 32'd100, 16'h0042, 2, 1'b0, 0, 1'b0, 32'd100, NO_PRED, 3);
    endtask

    task automatic test_ties;
        set_beat(0, 32'd10, 32'd10, 16'd4);
        set_beat(1, 32'd15, 32'd5, 16'd6);
        run_anchor("tie-beats", 32'd5, 16'h0010, 2, 1'b0, 0, 1'b0, 32'd20, 16'd4, 3);
        run_anchor("tie-seed", 32'd20, 16'h0011, 2, 1'b0, 0, 1'b0, 32'd20, NO_PRED, 3);
        run_anchor("zero-count", 32'd7, 16'h0012, 0, 1'b0, 0, 1'b0, 32'd7, NO_PRED, 1);
    endtask

    task automatic test_saturation;
        set_beat(0, 32'h7FFF_FFF0, 32'h0000_0100, 16'd5);
        run_anchor("sat-pos", 32'd0, 16'h0020, 1, 1'b0, 0, 1'b0, 32'h7FFF_FFFF, 16'd5, 2);
        set_beat(0, 32'h8000_0000, 32'hFFFF_FFFF, 16'd6);
        run_anchor("sat-neg", 32'd0, 16'h0021, 1, 1'b0, 0, 1'b0, 32'd0, NO_PRED, 2);
    endtask

    task automatic test_backpressure;
        set_beat(0, 32'd3, 32'd4, 16'd10);
        set_beat(1, -32'sd5, 32'd2, 16'd11);
        set_beat(2, 32'd100, -32'sd1, 16'd12);
        set_beat(3, 32'd99, 32'd0, 16'd13);
        run_anchor("backpressure", 32'd1, 16'h0555, 4, 1'b1, 5, 1'b1, 32'd99, 16'd12, -1);
    endtask

    task automatic test_back_to_back;
        set_beat(0, 32'd1, 32'd1, 16'd2);
        run_anchor("b2b-a", 32'd0, 16'h0A00, 1, 1'b0, 0, 1'b0, 32'd2, 16'd2, 2);
        set_beat(0, -32'sd1, -32'sd1, 16'd3);
        run_anchor("b2b-b", 32'd0, 16'h0A01, 1, 1'b0, 0, 1'b0, 32'd0, NO_PRED, 2);
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        start = 1'b1; w_i = 32'd5; anchor_idx = 16'h0077; num_pred = 8'd4;
        @(negedge clk);
        start = 1'b0;
        in_valid = 1'b1; in_fj = 32'd1000; in_score = 32'd0; in_pidx = 16'd30;
        @(negedge clk);
        in_fj = 32'd2000; in_pidx = 16'd31;
        @(negedge clk);
        in_fj = 32'd3000; in_pidx = 16'd32;
        reset = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset-mid: rdy=%b busy=%b v=%b, want 0 0 0", in_ready, busy, out_valid);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset-release: rdy=%b busy=%b v=%b, want 0 0 0", in_ready, busy, out_valid);
        end
        set_beat(0, 32'd1, 32'd1, 16'd20);
        set_beat(1, 32'd4, -32'sd1, 16'd21);
        run_anchor("after-reset", 32'd2, 16'h0078, 2, 1'b0, 0, 1'b0, 32'd3, 16'd21, 3);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_no_winner();
        test_ties();
        test_saturation();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
